// File: rtl/taglist_sequencer.sv
// Fetches one taglist entry and loops rom_addr over [start,end] on each step_en.
// Optional PB_EDGE_DETECT_EN: pb inputs are levels, requests are registered rising edges.
module taglist_sequencer #(
  parameter int IDX_W  = 6,
  parameter int ADDR_W = 10,
  parameter int SEQ_W  = 7
) (
  input  logic                      clk_1KHz,
  input  logic                      reset,
  input  logic                      tl_ready,
  input  logic                      pb_seq_up,
  input  logic                      pb_seq_dn,
  input  logic                      step_en,
  output logic [IDX_W-1:0]          tl_rdaddr,
  input  logic [SEQ_W+2*ADDR_W:0]   tl_rddata,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic                      rom_valid,
  output logic [SEQ_W-1:0]          seq_num,
  output logic                      tl_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;
  localparam logic [1:0] S_PLAY = 2'd3;

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_idx, r_last_idx;
  logic [ADDR_W-1:0] r_start, r_end, r_rom_addr;
  logic [SEQ_W-1:0]  r_seq;
  logic              r_last, r_err, r_go, r_pend_up, r_pend_dn;

  logic              w_up, w_dn;
  logic              w_p_up, w_p_dn, w_acc_up, w_acc_dn;
  logic              w_f_last, w_last_cur;
  logic [ADDR_W-1:0] w_f_start, w_f_end, w_rom_next;
  logic [SEQ_W-1:0]  w_f_seq;
  logic [IDX_W-1:0]  w_last_idx_cur, w_idx_up, w_idx_dn;

`ifdef PB_EDGE_DETECT_EN
  logic r_up_q, r_dn_q, r_up_req, r_dn_req;

  always_ff @(posedge clk_1KHz or negedge reset) begin
    if (!reset) begin
      r_up_q   <= 1'b0;
      r_dn_q   <= 1'b0;
      r_up_req <= 1'b0;
      r_dn_req <= 1'b0;
    end else begin
      r_up_q   <= pb_seq_up;
      r_dn_q   <= pb_seq_dn;
      r_up_req <= pb_seq_up & ~r_up_q;
      r_dn_req <= pb_seq_dn & ~r_dn_q;
    end
  end

  assign w_up = r_up_req;
  assign w_dn = r_dn_req;
`else
  assign w_up = pb_seq_up;
  assign w_dn = pb_seq_dn;
`endif

  assign w_f_last  = tl_rddata[0];
  assign w_f_end   = tl_rddata[ADDR_W:1];
  assign w_f_start = tl_rddata[2*ADDR_W:ADDR_W+1];
  assign w_f_seq   = tl_rddata[SEQ_W+2*ADDR_W:2*ADDR_W+1];

  // A request accepted on the capture edge must see the entry being captured.
  assign w_last_cur     = (r_state == S_CAP) ? w_f_last : r_last;
  assign w_last_idx_cur = (r_state == S_CAP && w_f_last) ? r_idx : r_last_idx;
  assign w_idx_up       = w_last_cur ? '0 : r_idx + 1'b1;
  assign w_idx_dn       = (r_idx == '0) ? w_last_idx_cur : r_idx - 1'b1;
  assign w_rom_next     = (r_rom_addr == r_end) ? r_start : r_rom_addr + 1'b1;

  always_comb begin
    w_p_up   = r_pend_up;
    w_p_dn   = r_pend_dn;
    w_acc_up = 1'b0;
    w_acc_dn = 1'b0;
    if (w_up && w_dn) begin
      w_p_up = 1'b0;
      w_p_dn = 1'b0;
    end else if (w_up) begin
      w_p_up = 1'b1;
      w_p_dn = 1'b0;
    end else if (w_dn) begin
      w_p_up = 1'b0;
      w_p_dn = 1'b1;
    end
    if (r_state == S_CAP) begin
      w_acc_up = w_p_up;
      w_acc_dn = w_p_dn;
    end else if (r_state == S_PLAY && !r_go) begin
      w_acc_up = w_up & ~w_dn;
      w_acc_dn = w_dn & ~w_up;
    end
  end

  always_ff @(posedge clk_1KHz or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_start    <= '0;
      r_end      <= '0;
      r_rom_addr <= '0;
      r_seq      <= '0;
      r_last     <= 1'b0;
      r_err      <= 1'b0;
      r_go       <= 1'b0;
      r_pend_up  <= 1'b0;
      r_pend_dn  <= 1'b0;
    end else begin
      r_last_idx <= w_last_idx_cur;
      if (w_acc_up)      r_idx <= w_idx_up;
      else if (w_acc_dn) r_idx <= w_idx_dn;
      case (r_state)
        S_IDLE: if (tl_ready) r_state <= S_RD;
        S_RD: begin
          r_pend_up <= w_p_up;
          r_pend_dn <= w_p_dn;
          r_state   <= S_CAP;
        end
        S_CAP: begin
          r_start    <= w_f_start;
          r_end      <= w_f_end;
          r_last     <= w_f_last;
          r_seq      <= w_f_seq;
          r_rom_addr <= w_f_start;
          r_err      <= (w_f_end < w_f_start);
          r_go       <= w_acc_up | w_acc_dn;
          r_pend_up  <= 1'b0;
          r_pend_dn  <= 1'b0;
          r_state    <= S_PLAY;
        end
        default: begin
          // r_go marks the one-cycle gap between accepting a request and refetching.
          if (r_go) begin
            r_go      <= 1'b0;
            r_pend_up <= w_p_up;
            r_pend_dn <= w_p_dn;
            r_state   <= S_RD;
          end else if (w_acc_up || w_acc_dn) begin
            r_go <= 1'b1;
          end
          if (step_en && !r_err) r_rom_addr <= w_rom_next;
        end
      endcase
    end
  end

  assign tl_rdaddr = r_idx;
  assign rom_addr  = r_rom_addr;
  assign rom_valid = (r_state == S_PLAY);
  assign seq_num   = r_seq;
  assign tl_err    = r_err;

endmodule

// File: tb/tb_taglist_sequencer.sv
// Randomized bench for taglist_sequencer against a playlist-level reference model.
module tb_taglist_sequencer;
  localparam int IDX_W  = 6;
  localparam int ADDR_W = 10;
  localparam int SEQ_W  = 7;
`ifdef PB_EDGE_DETECT_EN
  localparam int LAT  = 4;
  localparam int HOLD = 10;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 1;
`endif

  logic clk_1KHz = 1'b0;
  logic reset = 1'b0, tl_ready = 1'b0, pb_seq_up = 1'b0, pb_seq_dn = 1'b0, step_en = 1'b0;
  logic [IDX_W-1:0]  tl_rdaddr;
  logic [27:0]       tl_rddata;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_valid;
  logic [SEQ_W-1:0]  seq_num;
  logic              tl_err;

  taglist_sequencer #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .SEQ_W(SEQ_W)) dut (
    .clk_1KHz(clk_1KHz), .reset(reset), .tl_ready(tl_ready),
    .pb_seq_up(pb_seq_up), .pb_seq_dn(pb_seq_dn), .step_en(step_en),
    .tl_rdaddr(tl_rdaddr), .tl_rddata(tl_rddata), .rom_addr(rom_addr),
    .rom_valid(rom_valid), .seq_num(seq_num), .tl_err(tl_err)
  );

  always #5 clk_1KHz = ~clk_1KHz;

  typedef struct { int seq; int st; int en; bit last; } ent_t;
  ent_t        tbl [64];
  logic [27:0] mem [64];

  always @(posedge clk_1KHz) tl_rddata <= mem[tl_rdaddr];

  int   n_chk = 0, n_fail = 0;
  int   m_idx = 0, m_last_idx = 0, g_cnt = 0;
  ent_t act;

  task automatic set_entry(int i, int s, int st, int en, bit l);
    tbl[i] = '{s, st, en, l};
    mem[i] = {7'(s), 10'(st), 10'(en), l};
  endtask

  // Expected address after cnt accepted steps since the entry started playing.
  function automatic int exp_addr(ent_t e, int cnt);
    if (e.en < e.st) return e.st;
    return e.st + (cnt % (e.en - e.st + 1));
  endfunction

  task automatic activate();
    act = tbl[m_idx];
    if (act.last) m_last_idx = m_idx;
    g_cnt = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk_1KHz);
    reset = 1'b0; tl_ready = 1'b0; pb_seq_up = 1'b0; pb_seq_dn = 1'b0;
    repeat (2) @(negedge clk_1KHz);
    reset = 1'b1;
    m_idx = 0; m_last_idx = 0;
  endtask

  task automatic start_play(string tag);
    bit seen = 1'b0;
    step_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_1KHz);
      if (rom_valid === 1'b1) begin seen = 1'b1; break; end
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_start_timeout rom_valid=%b required 1 within 20 cycles", tag, rom_valid);
    end
    m_idx = 0;
    activate();
  endtask

  // Entered and left at an unsampled negedge while the DUT plays with no request in flight.
  task automatic req_and_play(string tag, bit up, bit dn, int ncyc, bit rnd);
    bit single = up ^ dn;
    int total;
    if (ncyc < HOLD) ncyc = HOLD;
    total = single ? LAT + 1 + ncyc : ncyc;
    if (single) begin
      if (up) m_idx = act.last ? 0 : (m_idx + 1) % 64;
      else    m_idx = (m_idx == 0) ? m_last_idx : m_idx - 1;
    end
    for (int c = 0; c < total; c++) begin
      bit play;
      play = !single || c == 0 || c >= LAT + 1;
      if (single && c == LAT + 1) activate();
      n_chk++;
      if (play) begin
        if (rom_valid !== 1'b1 || rom_addr !== ADDR_W'(exp_addr(act, g_cnt)) ||
            seq_num !== SEQ_W'(act.seq) || tl_err !== (act.en < act.st)) begin
          n_fail++;
          $display("FAIL %s_play c=%0d valid=%b addr=%h seq=%0d err=%b required valid=1 addr=%h seq=%0d err=%b",
                   tag, c, rom_valid, rom_addr, seq_num, tl_err,
                   ADDR_W'(exp_addr(act, g_cnt)), act.seq, act.en < act.st);
        end
      end else if (c >= LAT - 1) begin
        if (rom_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_refetch c=%0d rom_valid=%b required 0", tag, c, rom_valid);
        end
      end else begin
        if (rom_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL %s_accept c=%0d rom_valid=%b required 1", tag, c, rom_valid);
        end
      end
      pb_seq_up = up && (c < HOLD);
      pb_seq_dn = dn && (c < HOLD);
      step_en   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (play && step_en) g_cnt++;
      @(negedge clk_1KHz);
    end
    pb_seq_up = 1'b0;
    pb_seq_dn = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if (tl_rdaddr !== 0 || rom_addr !== 0 || rom_valid !== 0 || seq_num !== 0 || tl_err !== 0) begin
      n_fail++;
      $display("FAIL reset_values rdaddr=%h addr=%h valid=%b seq=%0d err=%b required all 0",
               tl_rdaddr, rom_addr, rom_valid, seq_num, tl_err);
    end
    step_en = 1'b1;
    repeat (4) @(negedge clk_1KHz);
    n_chk++;
    if (rom_valid !== 0 || rom_addr !== 0) begin
      n_fail++;
      $display("FAIL idle_wait valid=%b addr=%h required 0 0", rom_valid, rom_addr);
    end
  endtask

  task automatic test_start();
    tl_ready = 1'b1;
    start_play("start");
    req_and_play("wrap", 1'b0, 1'b0, 14, 1'b0);
  endtask

  task automatic test_up_seq();
    int exp_seq [5] = '{2, 3, 4, 5, 1};
    for (int i = 0; i < 5; i++) begin
      req_and_play("up", 1'b1, 1'b0, 26, 1'b0);
      n_chk++;
      if (seq_num !== SEQ_W'(exp_seq[i])) begin
        n_fail++;
        $display("FAIL up_seq%0d seq_num=%0d required %0d", i, seq_num, exp_seq[i]);
      end
    end
  endtask

  task automatic test_dn();
    req_and_play("dn_wrap", 1'b0, 1'b1, 12, 1'b0);
    n_chk++;
    if (seq_num !== 7'd5) begin
      n_fail++;
      $display("FAIL dn_to_last seq_num=%0d required 5", seq_num);
    end
    apply_reset();
    tl_ready = 1'b1;
    start_play("dn0");
    req_and_play("dn_nolast", 1'b0, 1'b1, 12, 1'b0);
    n_chk++;
    if (seq_num !== 7'd1) begin
      n_fail++;
      $display("FAIL dn_refetch0 seq_num=%0d required 1", seq_num);
    end
  endtask

  task automatic test_both();
    req_and_play("up", 1'b1, 1'b0, 12, 1'b0);
    req_and_play("both", 1'b1, 1'b1, 20, 1'b0);
  endtask

  task automatic test_random();
    tl_ready = 1'b0;
    repeat (25) begin
      int op = $urandom_range(0, 3);
      req_and_play("rand", op == 0 || op == 2, op == 1 || op == 2, $urandom_range(2, 15), 1'b1);
    end
    tl_ready = 1'b1;
  endtask

  task automatic test_err();
    set_entry(0, 7, 'h010, 'h008, 1'b1);
    apply_reset();
    tl_ready = 1'b1;
    start_play("err");
    req_and_play("err_hold", 1'b0, 1'b0, 12, 1'b1);
    req_and_play("err_up", 1'b1, 1'b0, 12, 1'b1);
    n_chk++;
    if (tl_err !== 1'b1 || rom_addr !== 10'h010 || seq_num !== 7'd7) begin
      n_fail++;
      $display("FAIL err_sticky err=%b addr=%h seq=%0d required 1 010 7", tl_err, rom_addr, seq_num);
    end
    set_entry(0, 1, 'h000, 'h005, 1'b0);
  endtask

  task automatic test_async_reset();
    apply_reset();
    tl_ready = 1'b1;
    start_play("ar");
    req_and_play("ar_up", 1'b1, 1'b0, 12, 1'b0);
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if (tl_rdaddr !== 0 || rom_addr !== 0 || rom_valid !== 0 || seq_num !== 0 || tl_err !== 0) begin
      n_fail++;
      $display("FAIL async_reset rdaddr=%h addr=%h valid=%b seq=%0d err=%b required all 0",
               tl_rdaddr, rom_addr, rom_valid, seq_num, tl_err);
    end
    repeat (2) @(negedge clk_1KHz);
    reset = 1'b1;
    m_idx = 0; m_last_idx = 0;
    start_play("restart");
    req_and_play("restart_play", 1'b0, 1'b0, 10, 1'b0);
    n_chk++;
    if (seq_num !== 7'd1) begin
      n_fail++;
      $display("FAIL restart_seq seq_num=%0d required 1", seq_num);
    end
    req_and_play("restart_up", 1'b1, 1'b0, 12, 1'b0);
    n_chk++;
    if (seq_num !== 7'd2) begin
      n_fail++;
      $display("FAIL single_advance seq_num=%0d required 2", seq_num);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) set_entry(i, 0, 0, 0, 1'b0);
    set_entry(0, 1, 'h000, 'h005, 1'b0);
    set_entry(1, 2, 'h006, 'h00C, 1'b0);
    set_entry(2, 3, 'h00D, 'h015, 1'b0);
    set_entry(3, 4, 'h016, 'h02A, 1'b0);
    set_entry(4, 5, 'h02B, 'h03F, 1'b1);
    test_reset();
    test_start();
    test_up_seq();
    test_dn();
    test_both();
    test_random();
    test_err();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
